tl_rx_ur_response_gen: RTL
==========================

Name: tl_rx_ur_response_gen

Overview:
Downstream stage of the RX unsupported-request checker. On every checked TLP header flagged UR, it queues a UR completion request (non-posted TLPs) toward the TX completion arbiter, or raises an ERR_NONFATAL message request (posted TLPs). It also maintains sticky UR status and a saturating UR counter for the config space.

Parameters:
FIFO_DEPTH, 4, completion-request queue entries (power of 2, >=2)
TAG_WIDTH, 10, tag width (Gen5 10-bit tags)
CNT_WIDTH, 16, UR event counter width

Ports:
clk  in  1  clock
arst  in  1  asynchronous active-high reset
chk_valid  in  1  one-cycle strobe: header fields and ur_error are valid this cycle
ur_error  in  1  UR result from the checker
typ  in  3  000 MEM, 001 IO, 010 CPL, 011 CFG, 100 MSG
read_write  in  1  0 read, 1 write
requester_id  in  16  header requester ID
tag  in  TAG_WIDTH  header tag
tc  in  3  traffic class
attr  in  3  attributes
lower_addr  in  7  address[6:0]
completer_id  in  16  own bus/dev/func from config
err_report_en  in  1  non-fatal error reporting enable (device control)
status_clr  in  1  clears ur_detected, ur_ovf, ur_cnt
cpl_valid  out  1  completion request available
cpl_ready  in  1  TX arbiter accepts
cpl_requester_id  out  16
cpl_tag  out  TAG_WIDTH
cpl_tc  out  3
cpl_attr  out  3
cpl_lower_addr  out  7
cpl_completer_id  out  16  completer_id sampled at enqueue
cpl_status  out  3  constant 3'b001 (UR)
msg_valid  out  1  error message request pending
msg_ready  in  1  TX message path accepts
msg_code  out  8  constant 8'h31 (ERR_NONFATAL)
ur_detected  out  1  sticky, any UR seen
ur_ovf  out  1  sticky, completion request dropped because the queue was full
ur_cnt  out  CNT_WIDTH  saturating count of UR events

Behaviour:
- Reset (arst=1, async): queue empty; cpl_valid=0, msg_valid=0, ur_detected=0, ur_ovf=0, ur_cnt=0; all cpl_* data outputs 0 except cpl_status=3'b001; msg_code=8'h31.
- UR event: chk_valid & ur_error. All other cycles are ignored.
- Classification:
  - Non-posted: typ=IO, typ=CFG, or typ=MEM with read_write=0.
  - Posted: MEM with read_write=1, or MSG.
  - typ=CPL or an invalid typ: counted and status only; no response.
- Non-posted event:
  - If the queue is not full, push {requester_id, tag, tc, attr, lower_addr, completer_id}.
  - If the queue is full, drop the entry and set ur_ovf.
  - cpl_valid rises the cycle after the push (one-cycle latency). The queue head drives cpl_* directly from registered storage.
- Pop occurs on cpl_valid & cpl_ready. Push and pop in the same cycle are both performed, including when the queue is full (the pop frees the slot, so a push on a full queue with a simultaneous pop is accepted). Pointers wrap modulo FIFO_DEPTH; occupancy uses a count of width log2(FIFO_DEPTH)+1.
- AXI-style handshake on cpl_*: cpl_valid and data stay stable until accepted. cpl_ready with no valid entry has no effect.
- Message FSM, states IDLE and PEND:
  - IDLE -> PEND on a posted event with err_report_en=1.
  - PEND -> IDLE on msg_ready. Further posted events in PEND are coalesced: no second message.
  - A posted event in the same cycle as the msg_ready handshake returns to PEND next cycle.
  - msg_valid = (state==PEND).
  - err_report_en deasserting in PEND does not withdraw the request.
- Status:
  - Any UR event sets ur_detected.
  - ur_cnt increments by 1 per UR event and saturates at all-ones.
  - status_clr in the same cycle as a UR event: clear wins for ur_ovf; ur_detected=1 and ur_cnt=1 after that cycle.
  - status_clr does not affect the queue or the FSM.
- Reset mid-operation: the queue is flushed and the FSM returns to IDLE immediately (asynchronously); pending requests are lost.

Test Plan:
- MEM read UR (typ=000, rw=0, requester_id=16'h0A01, tag=10'h155, lower_addr=7'h24), cpl_ready=1 -> cpl_valid for exactly 1 cycle starting next cycle with matching fields, cpl_status=001; ur_cnt=1, ur_detected=1, msg_valid=0.
- MEM write UR with err_report_en=1, msg_ready=0 for 5 cycles, 3 more posted URs -> msg_valid high with msg_code=8'h31; one handshake when msg_ready=1; msg_valid=0 after; ur_cnt=4.
- 5 CFG UR events with cpl_ready=0, FIFO_DEPTH=4 -> 4 queued, ur_ovf=1; then cpl_ready=1 -> 4 completions drained in FIFO order.
- Queue full, cpl_ready=1, new IO UR in the same cycle -> both pop and push accepted; ur_ovf stays 0; occupancy stays 4.
- UR event with typ=010 and an event with ur_error=0 -> no cpl/msg; ur_cnt +1 only for the first; then status_clr with a simultaneous UR -> ur_cnt=1, ur_ovf=0.
- arst asserted while 2 entries are queued and msg_valid=1 -> cpl_valid, msg_valid and all status outputs 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/tl_rx_ur_response_gen.sv
// ----------------------------------------------------------------------------
// tl_rx_ur_response_gen
//
// Sits after the RX unsupported-request checker. Every checked header that
// is flagged UR is turned into one of three outcomes:
//   - non-posted (IO, CFG, MEM read): a UR completion request is queued
//     toward the TX completion arbiter;
//   - posted (MEM write, MSG): an ERR_NONFATAL message request is raised,
//     if error reporting is enabled. Back-to-back requests are merged into
//     one while a request is still pending;
//   - anything else (CPL, reserved type codes): status update only.
// Sticky UR status and a saturating UR event counter are kept for config
// space.
//
// Ports
//   clk, arst           clock, asynchronous active-high reset
//   chk_valid           strobe: header fields and ur_error valid this cycle
//   ur_error            UR verdict from the checker
//   typ, read_write     TLP type (000 MEM,001 IO,010 CPL,011 CFG,100 MSG), 0=rd
//   requester_id, tag,
//   tc, attr,
//   lower_addr          header fields copied into the completion request
//   completer_id        own ID, captured when the request is queued
//   err_report_en       non-fatal error reporting enable
//   status_clr          clears ur_detected, ur_ovf, ur_cnt
//   cpl_*               completion request (valid/ready), head of queue
//   msg_valid/ready     ERR_NONFATAL message request handshake
//   msg_code            constant 8'h31
//   ur_detected         sticky: any UR seen
//   ur_ovf              sticky: a completion request was dropped (queue full)
//   ur_cnt              saturating UR event count
// ----------------------------------------------------------------------------
module tl_rx_ur_response_gen #(
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_WIDTH  = 10,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 arst,

    input  logic                 chk_valid,
    input  logic                 ur_error,
    input  logic [2:0]           typ,
    input  logic                 read_write,
    input  logic [15:0]          requester_id,
    input  logic [TAG_WIDTH-1:0] tag,
    input  logic [2:0]           tc,
    input  logic [2:0]           attr,
    input  logic [6:0]           lower_addr,
    input  logic [15:0]          completer_id,
    input  logic                 err_report_en,
    input  logic                 status_clr,

    output logic                 cpl_valid,
    input  logic                 cpl_ready,
    output logic [15:0]          cpl_requester_id,
    output logic [TAG_WIDTH-1:0] cpl_tag,
    output logic [2:0]           cpl_tc,
    output logic [2:0]           cpl_attr,
    output logic [6:0]           cpl_lower_addr,
    output logic [15:0]          cpl_completer_id,
    output logic [2:0]           cpl_status,

    output logic                 msg_valid,
    input  logic                 msg_ready,
    output logic [7:0]           msg_code,

    output logic                 ur_detected,
    output logic                 ur_ovf,
    output logic [CNT_WIDTH-1:0] ur_cnt
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [2:0] TYP_MEM = 3'b000;
    localparam logic [2:0] TYP_IO  = 3'b001;
    localparam logic [2:0] TYP_CFG = 3'b011;
    localparam logic [2:0] TYP_MSG = 3'b100;

    localparam logic [AW:0]          FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]          OCC_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0]        PTR_ONE  = AW'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PEND = 1'b1;

    // ------------------------------------------------------------------
    // Event decode
    // ------------------------------------------------------------------
    logic w_ur_evt;
    logic w_nonposted;
    logic w_posted;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;
    logic w_msg_trig;

    assign w_ur_evt    = chk_valid & ur_error;
    assign w_nonposted = (typ == TYP_IO) || (typ == TYP_CFG) ||
                         ((typ == TYP_MEM) && !read_write);
    assign w_posted    = ((typ == TYP_MEM) && read_write) || (typ == TYP_MSG);

    // ------------------------------------------------------------------
    // Completion request queue
    // ------------------------------------------------------------------
    logic [15:0]          r_rid_mem  [FIFO_DEPTH];
    logic [TAG_WIDTH-1:0] r_tag_mem  [FIFO_DEPTH];
    logic [2:0]           r_tc_mem   [FIFO_DEPTH];
    logic [2:0]           r_attr_mem [FIFO_DEPTH];
    logic [6:0]           r_la_mem   [FIFO_DEPTH];
    logic [15:0]          r_cid_mem  [FIFO_DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [AW:0]          r_count;

    assign w_full = (r_count == FULL_CNT);
    assign w_pop  = cpl_valid & cpl_ready;
    // A pop in the same cycle frees a slot, so a full queue still accepts.
    assign w_push = w_ur_evt & w_nonposted & (~w_full | w_pop);
    assign w_drop = w_ur_evt & w_nonposted & w_full & ~w_pop;

    // Storage is reset so the cpl_* outputs read zero while the queue is empty
    // after reset.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_rid_mem[i]  <= '0;
                r_tag_mem[i]  <= '0;
                r_tc_mem[i]   <= '0;
                r_attr_mem[i] <= '0;
                r_la_mem[i]   <= '0;
                r_cid_mem[i]  <= '0;
            end
        end else if (w_push) begin
            r_rid_mem[r_wr_ptr]  <= requester_id;
            r_tag_mem[r_wr_ptr]  <= tag;
            r_tc_mem[r_wr_ptr]   <= tc;
            r_attr_mem[r_wr_ptr] <= attr;
            r_la_mem[r_wr_ptr]   <= lower_addr;
            r_cid_mem[r_wr_ptr]  <= completer_id;
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + OCC_ONE;
                2'b01:   r_count <= r_count - OCC_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign cpl_valid        = (r_count != '0);
    assign cpl_requester_id = r_rid_mem[r_rd_ptr];
    assign cpl_tag          = r_tag_mem[r_rd_ptr];
    assign cpl_tc           = r_tc_mem[r_rd_ptr];
    assign cpl_attr         = r_attr_mem[r_rd_ptr];
    assign cpl_lower_addr   = r_la_mem[r_rd_ptr];
    assign cpl_completer_id = r_cid_mem[r_rd_ptr];
    assign cpl_status       = 3'b001;

    // ------------------------------------------------------------------
    // ERR_NONFATAL message FSM
    // ------------------------------------------------------------------
    logic [0:0] r_state;

    assign w_msg_trig = w_ur_evt & w_posted & err_report_en;

    // A new trigger during the accepting cycle re-arms the request for the
    // next cycle; triggers while still pending merge into the open request.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (w_msg_trig)               r_state <= ST_PEND;
                ST_PEND: if (msg_ready && !w_msg_trig) r_state <= ST_IDLE;
                default:                               r_state <= ST_IDLE;
            endcase
        end
    end

    assign msg_valid = (r_state == ST_PEND);
    assign msg_code  = 8'h31;

    // ------------------------------------------------------------------
    // Config-space status
    // ------------------------------------------------------------------
    logic                 r_ur_detected;
    logic                 r_ur_ovf;
    logic [CNT_WIDTH-1:0] r_ur_cnt;

    // On a clear coinciding with an event, the event is still recorded in
    // ur_detected/ur_cnt, but ur_ovf is cleared regardless.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_ur_detected <= 1'b0;
            r_ur_ovf      <= 1'b0;
            r_ur_cnt      <= '0;
        end else if (status_clr) begin
            r_ur_detected <= w_ur_evt;
            r_ur_ovf      <= 1'b0;
            r_ur_cnt      <= w_ur_evt ? CNT_ONE : '0;
        end else begin
            if (w_ur_evt) r_ur_detected <= 1'b1;
            if (w_drop)   r_ur_ovf      <= 1'b1;
            if (w_ur_evt && (r_ur_cnt != CNT_MAX))
                r_ur_cnt <= r_ur_cnt + CNT_ONE;
        end
    end

    assign ur_detected = r_ur_detected;
    assign ur_ovf      = r_ur_ovf;
    assign ur_cnt      = r_ur_cnt;

endmodule
